// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle, with sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Abort,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 divzero_q, divzero_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   div_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Op[0] selects the signed variants; magnitudes feed the unsigned datapath.
  assign a_mag = (Op[0] && DataA[WIDTH-1]) ? -DataA : DataA;
  assign b_mag = (Op[0] && DataB[WIDTH-1]) ? -DataB : DataB;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}. div_diff[WIDTH] is the borrow.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = (op_q[0] && neg_lo_q) ? -acc_q : acc_q;
  assign quo_fix  = (op_q[0] && neg_lo_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = (op_q[0] && neg_hi_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                          : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    unique case (state_q)
      StIdle: begin
        if (Start && !Abort) begin
          state_d  = StCalc;
          op_d     = Op;
          cnt_d    = CntW'(WIDTH - 1);
          neg_lo_d = DataA[WIDTH-1] ^ DataB[WIDTH-1];
          neg_hi_d = DataA[WIDTH-1];
          dz_d     = 1'b0;
          if (Op[1]) begin
            if (DataB == '0) begin
              // Preload the divide-by-zero result; CALC then passes straight to FIX.
              dz_d  = 1'b1;
              acc_d = {DataA, {WIDTH{1'b1}}};
              m_d   = '0;
              cnt_d = '0;
            end else begin
              acc_d = {{WIDTH{1'b0}}, a_mag};
              m_d   = b_mag;
            end
          end else begin
            acc_d = {{WIDTH{1'b0}}, b_mag};
            m_d   = a_mag;
          end
        end
      end
      StCalc: begin
        if (Abort) begin
          state_d = StIdle;
        end else begin
          if (!dz_q) acc_d = op_q[1] ? div_step : mul_step;
          if (cnt_q == '0) state_d = StFix;
          else cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!Abort) begin
          done_d    = 1'b1;
          divzero_d = dz_q;
          if (dz_q) begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
          end else if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      op_q      <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign Busy    = (state_q != StIdle);
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH = 32 with hand-computed results.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] DataA = '0;
  logic [31:0] DataB = '0;
  logic        Busy, Done, DivZero;
  logic [31:0] HI, LO;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .Op(Op),
    .DataA(DataA), .DataB(DataB), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Called 1ns after a rising edge; returns 1ns after the edge on which Done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int bsy);
    Start = 1'b1; Op = op; DataA = a; DataB = b;
    @(posedge CLK); #1;
    Start = 1'b0; DataA = $urandom; DataB = $urandom;
    cyc = 0; bsy = 0;
    while (!Done && cyc < 100) begin
      if (Busy) bsy++;
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({Busy, Done, DivZero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {Busy, Done, DivZero});
    end
    total++;
    if ({HI, LO} !== 64'h0) begin
      bad++; $display("FAIL reset_hilo: got %h want 0", {HI, LO});
    end
    #10 RST = 1'b1;
    @(posedge CLK); #1;
    // Abort beats Start in IDLE
    Start = 1'b1; Abort = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; Abort = 1'b0;
    total++;
    if (Busy !== 1'b0) begin
      bad++; $display("FAIL abort_priority: Busy got %b want 0", Busy);
    end
  endtask

  task automatic test_multu_max();
    int cyc, bsy;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bsy);
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL multu_latency: got %0d want 33", cyc); end
    total++;
    if (bsy !== 33) begin bad++; $display("FAIL multu_busy: got %0d want 33", bsy); end
    total++;
    if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL multu_max: got %h want fffffffe00000001", {HI, LO});
    end
    @(posedge CLK); #1;
    total++;
    if (Done !== 1'b0) begin bad++; $display("FAIL done_pulse: Done got %b want 0", Done); end
  endtask

  task automatic test_back_to_back();
    int cyc, bsy;
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, cyc, bsy);
    total++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      bad++; $display("FAIL mult_neg: got %h want fffffffffffffff1", {HI, LO});
    end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, cyc, bsy);
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
    total++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL div_neg: got %h want fffffffffffffffd", {HI, LO});
    end
    run_op(2'b11, 32'd7, 32'hFFFF_FFFE, cyc, bsy);
    total++;
    if ({HI, LO} !== 64'h0000_0001_FFFF_FFFD) begin
      bad++; $display("FAIL div_negdivisor: got %h want 00000001fffffffd", {HI, LO});
    end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bsy);
    total++;
    if ({HI, LO} !== 64'h0000_0000_0000_0001) begin
      bad++; $display("FAIL mult_negneg: got %h want 0000000000000001", {HI, LO});
    end
  endtask

  task automatic test_divzero();
    int cyc, bsy;
    run_op(2'b10, 32'd5, 32'd0, cyc, bsy);
    total++;
    if (cyc !== 2) begin bad++; $display("FAIL dz_latency: got %0d want 2", cyc); end
    total++;
    if (DivZero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", DivZero); end
    total++;
    if ({HI, LO} !== 64'h0000_0005_FFFF_FFFF) begin
      bad++; $display("FAIL dz_result: got %h want 00000005ffffffff", {HI, LO});
    end
    @(posedge CLK); #1;
    total++;
    if (DivZero !== 1'b1) begin bad++; $display("FAIL dz_hold: got %b want 1", DivZero); end
    run_op(2'b00, 32'd2, 32'd3, cyc, bsy);
    total++;
    if (DivZero !== 1'b0) begin bad++; $display("FAIL dz_clear: got %b want 0", DivZero); end
    total++;
    if ({HI, LO} !== 64'd6) begin bad++; $display("FAIL multu_small: got %h want 6", {HI, LO}); end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, cyc, bsy);
    total++;
    if ({DivZero, HI, LO} !== {1'b1, 64'hFFFF_FFF9_FFFF_FFFF}) begin
      bad++; $display("FAIL dz_signed: got %b %h want 1 fffffff9ffffffff", DivZero, {HI, LO});
    end
  endtask

  task automatic test_div_overflow();
    int cyc, bsy;
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bsy);
    total++;
    if ({DivZero, HI, LO} !== {1'b0, 64'h0000_0000_8000_0000}) begin
      bad++; $display("FAIL div_ovf: got %b %h want 0 0000000080000000", DivZero, {HI, LO});
    end
  endtask

  task automatic test_start_ignored_abort();
    int cyc, seen;
    Start = 1'b1; Op = 2'b00; DataA = 32'd7; DataB = 32'd9;
    @(posedge CLK); #1;
    Start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 9; i++) begin @(posedge CLK); #1; cyc++; end
    Start = 1'b1; Op = 2'b10; DataA = 32'd1; DataB = 32'd0;
    @(posedge CLK); #1; cyc++;
    Start = 1'b0;
    while (!Done && cyc < 100) begin @(posedge CLK); #1; cyc++; end
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL ignore_latency: got %0d want 33", cyc); end
    total++;
    if ({DivZero, HI, LO} !== {1'b0, 64'd63}) begin
      bad++; $display("FAIL ignore_result: got %b %h want 0 63", DivZero, {HI, LO});
    end
    Start = 1'b1; Op = 2'b00; DataA = 32'd5; DataB = 32'd5;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge CLK); #1; end
    Abort = 1'b1;
    @(posedge CLK); #1;
    Abort = 1'b0;
    total++;
    if ({Busy, Done} !== 2'b00) begin
      bad++; $display("FAIL abort_state: Busy/Done got %b want 00", {Busy, Done});
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge CLK); #1; if (Done) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_nodone: got %0d Done cycles want 0", seen); end
    total++;
    if ({HI, LO} !== 64'd63) begin bad++; $display("FAIL abort_hold: got %h want 63", {HI, LO}); end
  endtask

  task automatic test_reset_mid();
    int cyc, bsy;
    Start = 1'b1; Op = 2'b11; DataA = 32'hFFFF_FF9C; DataB = 32'd3;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int i = 0; i < 20; i++) begin @(posedge CLK); #1; end
    #2 RST = 1'b0;
    #1;
    total++;
    if ({Busy, Done, DivZero, HI, LO} !== 67'h0) begin
      bad++; $display("FAIL async_reset: got %b%b%b %h want all zero", Busy, Done, DivZero,
                      {HI, LO});
    end
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    run_op(2'b10, 32'd100, 32'd7, cyc, bsy);
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL divu_latency: got %0d want 33", cyc); end
    total++;
    if ({HI, LO} !== {32'd2, 32'd14}) begin
      bad++; $display("FAIL divu_result: got %h want 000000020000000e", {HI, LO});
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_divzero();
    test_div_overflow();
    test_start_ignored_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal values 8..64).
REQ-002 The block SHALL have port CLK  input  1  single clock, rising-edge active.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start  input  1  request to begin an operation, sampled on the CLK rising edge.
REQ-005 The block SHALL have port Abort  input  1  cancels the operation in progress.
REQ-006 The block SHALL have port Op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 The block SHALL have port DataA  input  WIDTH  multiplicand or dividend.
REQ-008 The block SHALL have port DataB  input  WIDTH  multiplier or divisor.
REQ-009 The block SHALL have port Busy  output  1  high while an operation is in progress.
REQ-010 The block SHALL have port Done  output  1  one-cycle pulse marking a completed result.
REQ-011 The block SHALL have port DivZero  output  1  flag set when a divide had divisor 0; valid while Done is high.
REQ-012 The block SHALL have port HI  output  WIDTH  product upper half, or divide remainder.
REQ-013 The block SHALL have port LO  output  WIDTH  product lower half, or divide quotient.

Function
REQ-014 The block SHALL implement FSM states IDLE, CALC and FIX, with Busy = (state != IDLE).
REQ-015 In IDLE, when Start = 1 and Abort = 0, the block SHALL, on that edge (t0):
- latch Op;
- latch operand magnitudes (absolute values for signed ops, raw values for unsigned ops);
- latch the result-sign information;
- load the iteration counter with WIDTH-1;
- enter CALC.
REQ-016 CALC SHALL perform one radix-2 step per cycle for exactly WIDTH cycles (edges t1..tWIDTH):
- multiply: shift-add;
- divide: restoring shift-subtract.
REQ-017 After the last CALC step the FSM SHALL enter FIX. On edge t(WIDTH+1) it SHALL:
- apply sign correction;
- write HI and LO;
- set Done = 1 for exactly one cycle;
- return to IDLE.
REQ-018 Total latency from the accepting edge to Done high SHALL be WIDTH+1 cycles (33 for WIDTH = 32).
REQ-019 For MULT the result SHALL be the 2*WIDTH-bit two's-complement product. For MULTU it SHALL be the unsigned product, with {HI,LO} = full product.
REQ-020 For DIV:
- the quotient SHALL be truncated toward zero;
- the remainder SHALL take the dividend's sign;
- the quotient SHALL be negated when the operand signs differ.
REQ-021 For DIV with DataA = most-negative value and DataB = -1, the result SHALL be LO = most-negative value and HI = 0, with no flag raised.
REQ-022 For DIVU or DIV with DataB = 0, the block SHALL bypass CALC and go to FIX on the next edge. It SHALL then produce HI = DataA, LO = all ones and DivZero = 1, with Done 2 cycles after the accepting edge.
REQ-023 DivZero SHALL be 0 for every multiply and every divide with a nonzero divisor. It SHALL hold its value until the next completion.
REQ-024 Start asserted while Busy = 1 SHALL be ignored; the operation in progress SHALL be unaffected.
REQ-025 Start asserted in the cycle Done is high SHALL be accepted (FSM is in IDLE), allowing back-to-back operations with no gap.
REQ-026 Abort = 1 on an edge in CALC or FIX SHALL return the FSM to IDLE with Done = 0 and HI, LO and DivZero unchanged.
REQ-027 Abort SHALL take priority over Start on the same edge.
REQ-028 HI and LO SHALL change only on a FIX edge or on reset. They SHALL hold the last result indefinitely.
REQ-029 Operand inputs SHALL be don't-care after the accepting edge.

Reset
REQ-030 RST = 0 SHALL, asynchronously and including mid-operation:
- force state to IDLE;
- set Busy = 0, Done = 0, DivZero = 0, HI = 0 and LO = 0;
- clear the iteration counter and internal accumulators.
REQ-031 After RST deasserts, the first rising edge SHALL be able to accept Start.

Verification
REQ-032 MULTU with DataA = 0xFFFFFFFF and DataB = 0xFFFFFFFF -> HI = 0xFFFFFFFE and LO = 0x00000001, with Done exactly 33 cycles after Start and Busy high for 33 cycles.
REQ-033 MULT -3 x 5 -> HI = 0xFFFFFFFF and LO = 0xFFFFFFF1. Then, back-to-back on the Done cycle, DIV -7 / 2 -> LO = 0xFFFFFFFD and HI = 0xFFFFFFFF.
REQ-034 DIVU 5 / 0 -> Done 2 cycles after Start, with DivZero = 1, HI = 0x00000005 and LO = 0xFFFFFFFF. The next MULTU 2 x 3 -> DivZero = 0, HI = 0 and LO = 6.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0 and DivZero = 0.
REQ-036 Start a MULTU 7 x 9 then re-pulse Start at cycle 10 -> the second pulse is ignored and the result is LO = 63 at cycle 33. Start again, Abort at cycle 5 -> no Done, HI and LO still 0 and 63, Busy = 0 next cycle.
REQ-037 RST driven low at cycle 20 of a DIV -> all outputs 0 immediately without waiting for a clock edge. After release, a new DIVU 100 / 7 -> LO = 14 and HI = 2.
